// File: rtl/modbus_frame_rx_if.sv
// Byte stream from the UART receiver into the Modbus RTU framer.
interface modbus_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input rx_data, input rx_valid);
endinterface

// File: rtl/modbus_frame_rx.sv
// Modbus RTU receive framer: delimits frames by line silence, filters on slave
// address and length, and hands the payload plus received CRC to the CRC checker.
module modbus_frame_rx #(
    parameter int BYTES      = 6,
    parameter int T15_CYCLES = 'd1563,
    parameter int T35_CYCLES = 'd3646,
    parameter int CW         = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    modbus_frame_rx_if.slave     rx,
    input  logic [7:0]           dev_addr,
    output logic [8*BYTES-1:0]   frame_data,
    output logic [15:0]          rx_crc,
    output logic                 rx_message_done,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int FRAME_LEN = BYTES + 2;
    localparam int NW        = $clog2(FRAME_LEN + 1);

    localparam logic [CW-1:0] T15    = CW'(T15_CYCLES);
    localparam logic [CW-1:0] T35    = CW'(T35_CYCLES);
    localparam logic [NW-1:0] LEN    = NW'(FRAME_LEN);
    localparam logic [NW-1:0] CRC_LO = NW'(BYTES);
    localparam logic [NW-1:0] CRC_HI = NW'(BYTES + 1);

    typedef enum logic [1:0] {INIT, IDLE, RECV, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        timer;
    logic [NW-1:0]        count;
    logic [8*BYTES-1:0]   shadow_data;
    logic [15:0]          shadow_crc;
    logic                 addr_ok, err, ovf;

    logic load_first, store_byte, set_err, set_ovf, publish, raise_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= INIT;
        else           state <= state_next;
    end

    // A byte and end-of-frame silence in the same cycle: the byte wins.
    always_comb begin
        state_next = state;
        load_first = 1'b0;
        store_byte = 1'b0;
        set_err    = 1'b0;
        set_ovf    = 1'b0;
        publish    = 1'b0;
        raise_err  = 1'b0;
        case (state)
            INIT: begin
                if (!rx.rx_valid && timer == T35) state_next = IDLE;
            end
            IDLE: begin
                if (rx.rx_valid) begin
                    load_first = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (rx.rx_valid) begin
                    if (timer >= T15) set_err = 1'b1;
                    if (count < LEN) store_byte = 1'b1;
                    else             set_ovf    = 1'b1;
                end else if (timer == T35) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (addr_ok) begin
                    if (count == LEN && !err && !ovf) publish   = 1'b1;
                    else                               raise_err = 1'b1;
                end
                if (rx.rx_valid) begin
                    load_first = 1'b1;
                    state_next = RECV;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)          timer <= '0;
        else if (rx.rx_valid)   timer <= '0;
        else if (timer != T35)  timer <= timer + CW'(1);
    end

    // Bytes land in shadow registers; outputs only change on a clean frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count           <= '0;
            shadow_data     <= '0;
            shadow_crc      <= '0;
            addr_ok         <= 1'b0;
            err             <= 1'b0;
            ovf             <= 1'b0;
            frame_data      <= '0;
            rx_crc          <= '0;
            rx_message_done <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            rx_message_done <= publish;
            frame_err       <= raise_err;
            if (publish) begin
                frame_data <= shadow_data;
                rx_crc     <= shadow_crc;
            end
            if (load_first) begin
                shadow_data[7:0] <= rx.rx_data;
                count            <= NW'(1);
                addr_ok          <= (rx.rx_data == dev_addr) || (rx.rx_data == 8'h00);
                err              <= 1'b0;
                ovf              <= 1'b0;
            end
            if (store_byte) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (count == NW'(i)) shadow_data[8*i +: 8] <= rx.rx_data;
                end
                if (count == CRC_LO) shadow_crc[7:0]  <= rx.rx_data;
                if (count == CRC_HI) shadow_crc[15:8] <= rx.rx_data;
                count <= count + NW'(1);
            end
            if (set_err) err <= 1'b1;
            if (set_ovf) ovf <= 1'b1;
        end
    end

    assign busy = (state == RECV);
endmodule

// File: tb/tb_modbus_frame_rx.sv
// Scoreboard bench for modbus_frame_rx: frames are driven byte by byte and the
// expected pulse, payload, CRC and arrival cycle are queued for the monitor.
module tb_modbus_frame_rx;
    localparam int BYTES   = 6;
    localparam int T15     = 1563;
    localparam int T35     = 3646;
    localparam int SPACING = 10;

    typedef struct {
        bit          is_done;
        logic [47:0] data;
        logic [15:0] crc;
        longint      due;
    } sb_entry_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [7:0]  dev_addr = 8'h01;
    logic [47:0] frame_data;
    logic [15:0] rx_crc;
    logic        rx_message_done, frame_err, busy;

    longint      cyc = 0;
    longint      last_drive = 0;
    int          vectors = 0;
    int          miscompares = 0;
    sb_entry_t   sb[$];
    logic [7:0]  fr [10];

    modbus_frame_rx_if bus ();

    modbus_frame_rx #(
        .BYTES(BYTES), .T15_CYCLES(T15), .T35_CYCLES(T35), .CW(16)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .rx(bus.slave),
        .dev_addr(dev_addr),
        .frame_data(frame_data),
        .rx_crc(rx_crc),
        .rx_message_done(rx_message_done),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every pulse must match the head of the scoreboard, including its cycle.
    always @(negedge clk_in) begin
        if (rst_n_in && (rx_message_done || frame_err)) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_pulse", {62'd0, rx_message_done, frame_err}, 64'd0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                checkOutput("pulse_kind", {62'd0, rx_message_done, frame_err},
                            e.is_done ? 64'd2 : 64'd1);
                checkOutput("pulse_latency", cyc, e.due);
                if (e.is_done) begin
                    checkOutput("frame_data", frame_data, e.data);
                    checkOutput("rx_crc", rx_crc, e.crc);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk_in);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_drive   = cyc;
        @(negedge clk_in);
        bus.rx_valid = 1'b0;
    endtask

    // Sends n bytes; idle cycles after byte gap_idx are gap_len instead of SPACING-1.
    task automatic applyStimulus(input logic [7:0] f [10], input int n, input int gap_idx,
                                 input int gap_len, input bit accepted, input bit exp_busy);
        int        max_idle;
        sb_entry_t e;
        max_idle = 0;
        for (int k = 0; k < n; k++) begin
            sendByte(f[k]);
            if (k == 0) checkOutput("busy", {63'd0, busy}, {63'd0, exp_busy});
            if (k < n - 1) begin
                int idle;
                idle = (k == gap_idx) ? gap_len : SPACING - 1;
                if (idle > max_idle) max_idle = idle;
                repeat (idle - 1) @(negedge clk_in);
            end
        end
        if (accepted && (f[0] == dev_addr || f[0] == 8'h00)) begin
            e.is_done = (n == BYTES + 2) && (max_idle < T15);
            for (int k = 0; k < BYTES; k++) e.data[8*k +: 8] = f[k];
            e.crc = {f[7], f[6]};
            e.due = last_drive + T35 + 3;
            sb.push_back(e);
        end
    endtask

    task automatic waitDrain();
        waitCycles(T35 + 10);
        checkOutput("sb_drain", sb.size(), 64'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_frame_data", frame_data, 64'd0);
        checkOutput("rst_rx_crc", rx_crc, 64'd0);
        checkOutput("rst_done", {63'd0, rx_message_done}, 64'd0);
        checkOutput("rst_err", {63'd0, frame_err}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        rst_n_in = 1'b1;

        // Bytes right after reset release fall into the startup silence window.
        fr = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 8'h00, 8'h00};
        applyStimulus(fr, 8, -1, 0, 1'b0, 1'b0);
        waitDrain();

        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("good_data", frame_data, 64'h0A0000000301);
        checkOutput("good_crc", rx_crc, 64'hCDC5);

        fr[0] = 8'h05;
        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("filtered_hold", frame_data, 64'h0A0000000301);

        fr[0] = 8'h00;
        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("bcast_addr", frame_data[7:0], 64'h00);

        fr[0] = 8'h01;
        applyStimulus(fr, 7, -1, 0, 1'b1, 1'b1);
        waitDrain();

        fr[8] = 8'hFF;
        applyStimulus(fr, 9, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("long_hold", frame_data, 64'h0A0000000300);

        applyStimulus(fr, 8, 3, T15 + 5, 1'b1, 1'b1);
        waitDrain();

        for (int k = 0; k < 4; k++) begin
            sendByte(fr[k]);
            waitCycles(SPACING - 2);
        end
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_data", frame_data, 64'd0);
        waitCycles(3);
        rst_n_in = 1'b1;
        waitCycles(T35 + 10);
        fr = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h95, 8'hCB, 8'h00, 8'h00};
        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("postrst_data", frame_data, 64'h020001000301);

        // Second frame starts exactly in the DONE cycle of the first.
        fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B, 8'h00, 8'h00};
        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitCycles(T35);
        fr = '{8'h01, 8'h03, 8'h00, 8'h10, 8'h00, 8'h02, 8'hC5, 8'hCE, 8'h00, 8'h00};
        applyStimulus(fr, 8, -1, 0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("b2b_last_data", frame_data, 64'h020010000301);
        checkOutput("b2b_last_crc", rx_crc, 64'hCEC5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/modbus_frame_rx.md
Name: modbus_frame_rx

Overview:
- Receive-side framer, directly upstream of the Modbus CRC checker.
- Consumes the byte stream from the UART receiver and delimits RTU frames by line silence (t1.5 / t3.5).
- Filters frames on slave address and checks frame length.
- For each valid frame, presents the payload on frame_data with a one-cycle rx_message_done, which feeds the CRC checker's data_in and rx_message_done. The received CRC is presented on rx_crc for comparison against crc_out.

Parameters:
- BYTES, 6: payload bytes per frame, excluding CRC. A frame is exactly BYTES+2 bytes on the wire.
- T15_CYCLES, 'd1563: clocks of silence equal to 1.5 character times.
- T35_CYCLES, 'd3646: clocks of silence equal to 3.5 character times. Must be greater than T15_CYCLES.
- CW, 16: width of the silence timer. Must satisfy 2^CW > T35_CYCLES.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: asynchronous reset, active low.
- rx_data, input, 8: byte from the UART receiver.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid in that cycle.
- dev_addr, input, 8: this slave's address. Sampled when the first byte of a frame arrives.
- frame_data, output, 8*BYTES: payload. Byte 0 (address) is in [7:0]; byte k is in [8k+7:8k].
- rx_crc, output, 16: received CRC, {high byte, low byte}. The low byte arrives first on the wire.
- rx_message_done, output, 1: one-cycle pulse; frame_data and rx_crc are valid.
- frame_err, output, 1: one-cycle pulse for a malformed frame addressed to this slave or to broadcast.
- busy, output, 1: high while in the RECV state.

Behaviour:
- Reset: all outputs are 0, state is INIT, timer is 0, byte count is 0, error flags are clear. Reset mid-frame discards the partial frame; no pulse is produced.
- Timer:
  - Cleared to 0 on any cycle with rx_valid=1.
  - Otherwise increments each cycle and saturates at T35_CYCLES.
- State INIT:
  - Waits for timer == T35_CYCLES, then goes to IDLE. Bytes arriving during INIT restart the wait and are discarded.
  - Guarantees that no frame is accepted mid-stream after reset.
- State IDLE:
  - On rx_valid: store rx_data as byte 0, set count=1.
  - addr_ok = (rx_data == dev_addr) or (rx_data == 8'h00).
  - Clear the err and ovf flags; go to RECV.
- State RECV, on rx_valid:
  - If timer ≥ T15_CYCLES, set err (inter-character gap violation).
  - If count < BYTES+2, store the byte at index count and increment count. Otherwise set ovf and discard the byte.
  - Bytes BYTES and BYTES+1 go to rx_crc[7:0] and rx_crc[15:8] respectively, not to frame_data.
- State RECV, on timer == T35_CYCLES with rx_valid=0: go to DONE.
- Simultaneous rx_valid and timer == T35_CYCLES: rx_valid wins. The byte belongs to the current frame and sets err.
- State DONE (one cycle):
  - If !addr_ok: no pulse (silent drop).
  - Else if count == BYTES+2 and !err and !ovf: update frame_data/rx_crc from the shadow registers and pulse rx_message_done.
  - Else: pulse frame_err.
  - In all cases, return to IDLE.
- Pulse latency: rx_message_done and frame_err are registered. They are high exactly T35_CYCLES+2 clocks after the edge that sampled the last rx_valid, and stay high for one cycle.
- Output holding:
  - frame_data and rx_crc hold their values until the next successful frame.
  - Bytes are assembled in shadow registers, so dropped or errored frames never alter the outputs.
- rx_valid arriving in DONE: treated as byte 0 of a new frame, with the IDLE rules applied in the same cycle.
- The block performs no CRC computation. The downstream CRC checker latches frame_data on rx_message_done.

Test Plan:
- Good frame: dev_addr=8'h01; after INIT silence, send 01 03 00 00 00 0A C5 CD with 10-cycle spacing -> one rx_message_done pulse T35_CYCLES+2 clocks after the last byte; frame_data=48'h0A0000000301; rx_crc=16'hCDC5; frame_err stays 0.
- Address filter: the same frame with first byte 8'h05 -> no rx_message_done, no frame_err, outputs unchanged. The same frame with first byte 8'h00 -> rx_message_done=1 and frame_data[7:0]=8'h00.
- Length errors:
  - 7 bytes then silence -> frame_err=1 and rx_message_done=0.
  - 9 bytes then silence -> frame_err=1; frame_data retains the previous good frame.
- Gap violation: insert a T15_CYCLES+5 cycle gap between bytes 3 and 4, all bytes otherwise correct -> frame_err=1.
- Startup and reset:
  - Bytes arriving within T35_CYCLES of reset release are ignored, with no pulse.
  - Assert rst_n_in mid-frame, release, then send a good frame after silence -> exactly one rx_message_done, carrying the new frame's data.
- Back-to-back frames: two good frames separated by exactly T35_CYCLES+1 idle cycles -> two rx_message_done pulses, each with its own frame_data.
